// File: rtl/acc_pkg.sv
// Shared operation codes and source-select constants for the accumulator/stack datapath.
package acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_PUSH  = 3'b010,
    OP_POP   = 3'b011,
    OP_SWAP  = 3'b100,
    OP_CLR   = 3'b101,
    OP_FLUSH = 3'b110,
    OP_RSVD  = 3'b111
  } acc_op_e;

  // SEL_ALU is the canonical code; any SelAcc with bit 1 set selects the ALU.
  localparam logic [1:0] SEL_IMM = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

endpackage

// File: rtl/acc_lifo.sv
// Save/restore LIFO: DEPTH x WIDTH storage with occupancy count.
// Trusts its controls; the caller blocks push-when-full and pop/swap-when-empty.
module acc_lifo
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             CLB,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] top_s;

  // Occupancy counter; storage itself is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (CLB) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else if (push) begin
      count_r <= count_r + CW'(1);
    end else if (pop) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry writes: push fills slot [count], swap overwrites slot [count-1].
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (count_r == CW'(i))) begin
        mem_r[i] <= wdata;
      end else if (swap && (count_r == CW'(i + 1))) begin
        mem_r[i] <= wdata;
      end else begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

  // Top-of-stack mux; no slot matches count==0, so an empty stack reads zero.
  always_comb begin
    top_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (count_r == CW'(i + 1)) ? mem_r[i] : top_s;
    end
  end

  assign top   = top_s;
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/acc_stack.sv
// Accumulator with save/restore LIFO, sticky error and zero flag.
// Define ACC_IMM_SEXT_EN to sign-extend the immediate on LOAD (default: zero-extend).
module acc_stack
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             CLB,
  input  logic [WIDTH-1:0] aluIn,
  input  logic [WIDTH-1:0] regIn,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       SelAcc,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] Acc,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic             zero
);

  logic [WIDTH-1:0] acc_r, acc_nxt_s, src_s, imm_ext_s, top_s;
  logic             err_r, err_nxt_s;
  logic             push_s, pop_s, swap_s, flush_s;
  logic             full_s, empty_s;
  acc_op_e          op_s;

`ifdef ACC_IMM_SEXT_EN
  assign imm_ext_s = WIDTH'($signed(imm));
`else
  assign imm_ext_s = WIDTH'(imm);
`endif

  // LOAD source select.
  always_comb begin
    if (SelAcc[1]) begin
      src_s = aluIn;
    end else if (SelAcc == SEL_REG) begin
      src_s = regIn;
    end else begin
      src_s = imm_ext_s;
    end
  end

  // Op decode; illegal stack ops are dropped here and only raise err.
  always_comb begin
    op_s      = acc_op_e'(op);
    acc_nxt_s = acc_r;
    err_nxt_s = err_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    swap_s    = 1'b0;
    flush_s   = 1'b0;
    if (CLB) begin
      acc_nxt_s = '0;
      err_nxt_s = 1'b0;
    end else begin
      case (op_s)
        OP_LOAD: acc_nxt_s = src_s;
        OP_PUSH: begin
          if (full_s) begin
            err_nxt_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        OP_POP, OP_SWAP: begin
          if (empty_s) begin
            err_nxt_s = 1'b1;
          end else begin
            acc_nxt_s = top_s;
            pop_s     = (op_s == OP_POP);
            swap_s    = (op_s == OP_SWAP);
          end
        end
        OP_CLR: begin
          acc_nxt_s = '0;
          err_nxt_s = 1'b0;
        end
        OP_FLUSH: flush_s = 1'b1;
        default:  acc_nxt_s = acc_r;
      endcase
    end
  end

  // Accumulator and sticky error registers.
  always_ff @(posedge clk) begin
    if (CLB) begin
      acc_r <= '0;
      err_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  acc_lifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_lifo (
    .clk  (clk),
    .CLB  (CLB),
    .push (push_s),
    .pop  (pop_s),
    .swap (swap_s),
    .flush(flush_s),
    .wdata(acc_r),
    .top  (top_s),
    .count(count),
    .full (full_s),
    .empty(empty_s)
  );

  assign Acc   = acc_r;
  assign top   = top_s;
  assign full  = full_s;
  assign empty = empty_s;
  assign err   = err_r;
  assign zero  = (acc_r == '0);

endmodule

// File: tb/tb_acc_stack.sv
// Scoreboard bench for acc_stack: stimulus queues expected state, monitor compares after each edge.
module tb_acc_stack;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, PUSH = 3'b010, POP = 3'b011;
  localparam logic [2:0] SWAP = 3'b100, CLR = 3'b101, FLUSH = 3'b110, RSVD = 3'b111;
`ifdef ACC_IMM_SEXT_EN
  localparam logic [7:0] IMMA = 8'hFA;
`else
  localparam logic [7:0] IMMA = 8'h0A;
`endif

  logic       clk = 1'b0;
  logic       CLB = 1'b1;
  logic [7:0] aluIn = 8'h00, regIn = 8'h00;
  logic [3:0] imm = 4'h0;
  logic [1:0] SelAcc = 2'b00;
  logic [2:0] op = 3'b000;
  logic [7:0] Acc, top;
  logic [2:0] count;
  logic       full, empty, err, zero;

  typedef struct {
    string      name;
    logic       chk;
    logic [7:0] acc;
    logic [7:0] top;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  acc_stack dut (
    .clk(clk), .CLB(CLB), .aluIn(aluIn), .regIn(regIn), .imm(imm),
    .SelAcc(SelAcc), .op(op), .Acc(Acc), .top(top), .count(count),
    .full(full), .empty(empty), .err(err), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] o, input logic [1:0] s, input logic [7:0] a,
                      input logic [7:0] r, input logic [3:0] im, input logic rst,
                      input logic chk, input logic [7:0] eacc, input logic [7:0] etop,
                      input logic [2:0] ecnt, input logic eerr, input string nm);
    exp_t e;
    @(negedge clk);
    op = o; SelAcc = s; aluIn = a; regIn = r; imm = im; CLB = rst;
    e.name = nm; e.chk = chk; e.acc = eacc; e.top = etop; e.cnt = ecnt; e.err = eerr;
    q.push_back(e);
  endtask

  // Monitor: every edge presents new state; pop the matching expectation.
  initial begin
    exp_t e;
    logic efull, eempty, ezero;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          efull  = (e.cnt == 3'd4);
          eempty = (e.cnt == 3'd0);
          ezero  = (e.acc == 8'h00);
          total++;
          if (Acc !== e.acc || top !== e.top || count !== e.cnt || err !== e.err ||
              full !== efull || empty !== eempty || zero !== ezero) begin
            bad++;
            $display("FAIL %s: got acc=%h top=%h cnt=%0d err=%b full=%b empty=%b zero=%b, want acc=%h top=%h cnt=%0d err=%b full=%b empty=%b zero=%b",
                     e.name, Acc, top, count, err, full, empty, zero,
                     e.acc, e.top, e.cnt, e.err, efull, eempty, ezero);
          end
        end
      end
    end
  end

  initial begin
    // Load sources and basic push/pop
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "reset");
    step(LOAD,  2'b00, 8'h00, 8'h00, 4'hA, 1'b0, 1'b1, IMMA,  8'h00, 3'd0, 1'b0, "ld_imm");
    step(LOAD,  2'b10, 8'h11, 8'h00, 4'h0, 1'b0, 1'b1, 8'h11, 8'h00, 3'd0, 1'b0, "ld_alu");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h11, 8'h11, 3'd1, 1'b0, "push1");
    step(LOAD,  2'b01, 8'h00, 8'h22, 4'h0, 1'b0, 1'b1, 8'h22, 8'h11, 3'd1, 1'b0, "ld_reg");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h22, 8'h22, 3'd2, 1'b0, "push2");
    step(POP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h22, 8'h11, 3'd1, 1'b0, "pop");
    step(LOAD,  2'b11, 8'h33, 8'h44, 4'h0, 1'b0, 1'b1, 8'h33, 8'h11, 3'd1, 1'b0, "ld_sel11");

    // Fill to full, overflow, clear, pop and flush
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset2");
    for (int v = 1; v <= 4; v++) begin
      step(LOAD, 2'b10, 8'(v), 8'h00, 4'h0, 1'b0, 1'b1, 8'(v), 8'(v - 1), 3'(v - 1), 1'b0, "fill_ld");
      step(PUSH, 2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'(v), 8'(v),     3'(v),     1'b0, "fill_push");
    end
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h04, 8'h04, 3'd4, 1'b1, "push_full");
    step(CLR,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h04, 3'd4, 1'b0, "clr");
    step(POP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h04, 8'h03, 3'd3, 1'b0, "pop_from_full");
    step(FLUSH, 2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h04, 8'h00, 3'd0, 1'b0, "flush");

    // Underflow and sticky error
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset3");
    step(POP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, "pop_empty");
    step(LOAD,  2'b00, 8'h00, 8'h00, 4'h5, 1'b0, 1'b1, 8'h05, 8'h00, 3'd0, 1'b1, "err_sticky");
    step(SWAP,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h05, 8'h00, 3'd0, 1'b1, "swap_empty");
    step(CLR,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "clr_err");

    // Swap, reserved op and NOP
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset4");
    step(LOAD,  2'b10, 8'hAA, 8'h00, 4'h0, 1'b0, 1'b1, 8'hAA, 8'h00, 3'd0, 1'b0, "ld_aa");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'hAA, 8'hAA, 3'd1, 1'b0, "push_aa");
    step(LOAD,  2'b10, 8'h55, 8'h00, 4'h0, 1'b0, 1'b1, 8'h55, 8'hAA, 3'd1, 1'b0, "ld_55");
    step(SWAP,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, "swap");
    step(RSVD,  2'b10, 8'h99, 8'h00, 4'h0, 1'b0, 1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, "reserved");
    step(NOP,   2'b10, 8'h99, 8'h00, 4'h0, 1'b0, 1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, "nop");

    // Reset overrides an op in the same cycle
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "reset5");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd1, 1'b0, "push_a");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0, "push_b");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, "push_c");
    step(PUSH,  2'b00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "push_with_rst");
    step(LOAD,  2'b10, 8'h77, 8'h00, 4'h0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "load_with_rst");
    step(NOP,   2'b00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "idle");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
